// File: rtl/arm_defs_pkg.sv
// ARM-subset encodings shared by the decode stage: instruction modes, opcodes, ALU commands,
// condition codes, NZCV bit positions and the condition-check helper.
package arm_defs_pkg;

    typedef enum logic [1:0] {
        MODE_DP  = 2'b00,
        MODE_MEM = 2'b01,
        MODE_BR  = 2'b10,
        MODE_NOP = 2'b11
    } modeT;

    typedef enum logic [3:0] {
        OP_AND = 4'b0000, OP_EOR = 4'b0001, OP_SUB = 4'b0010, OP_ADD = 4'b0100,
        OP_ADC = 4'b0101, OP_SBC = 4'b0110, OP_TST = 4'b1000, OP_CMP = 4'b1010,
        OP_ORR = 4'b1100, OP_MOV = 4'b1101, OP_MVN = 4'b1111
    } opcodeT;

    localparam logic [3:0] OP_LDST = 4'b0100;
    localparam logic [3:0] REG_PC  = 4'd15;

    typedef enum logic [3:0] {
        CMD_NONE = 4'b0000, CMD_MOV = 4'b0001, CMD_ADD = 4'b0010, CMD_ADC = 4'b0011,
        CMD_SUB  = 4'b0100, CMD_SBC = 4'b0101, CMD_AND = 4'b0110, CMD_ORR = 4'b0111,
        CMD_EOR  = 4'b1000, CMD_MVN = 4'b1001
    } exeCmdT;

    typedef enum logic [3:0] {
        COND_EQ = 4'b0000, COND_NE = 4'b0001, COND_CS = 4'b0010, COND_CC = 4'b0011,
        COND_MI = 4'b0100, COND_PL = 4'b0101, COND_VS = 4'b0110, COND_VC = 4'b0111,
        COND_HI = 4'b1000, COND_LS = 4'b1001, COND_GE = 4'b1010, COND_LT = 4'b1011,
        COND_GT = 4'b1100, COND_LE = 4'b1101, COND_AL = 4'b1110, COND_NV = 4'b1111
    } condT;

    localparam int STATUS_N = 3;
    localparam int STATUS_Z = 2;
    localparam int STATUS_C = 1;
    localparam int STATUS_V = 0;

    function automatic logic condPass(input logic [3:0] cond, input logic [3:0] nzcv);
        logic n, z, c, v;
        n = nzcv[STATUS_N];
        z = nzcv[STATUS_Z];
        c = nzcv[STATUS_C];
        v = nzcv[STATUS_V];
        case (cond)
            COND_EQ: condPass = z;
            COND_NE: condPass = ~z;
            COND_CS: condPass = c;
            COND_CC: condPass = ~c;
            COND_MI: condPass = n;
            COND_PL: condPass = ~n;
            COND_VS: condPass = v;
            COND_VC: condPass = ~v;
            COND_HI: condPass = c & ~z;
            COND_LS: condPass = ~c | z;
            COND_GE: condPass = (n == v);
            COND_LT: condPass = (n != v);
            COND_GT: condPass = ~z & (n == v);
            COND_LE: condPass = z | (n != v);
            COND_AL: condPass = 1'b1;
            default: condPass = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/register_file.sv
// R0..R14 register file: two combinational read ports (index 15 returns the pc), one write port
// with write-through; latency 0 on reads, write lands on the clock edge; no backpressure.
module register_file
    import arm_defs_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int NUM_REGS = 15
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] pcVal,
    input  logic [3:0]       rdAddr1,
    input  logic [3:0]       rdAddr2,
    output logic [WIDTH-1:0] rdData1,
    output logic [WIDTH-1:0] rdData2,
    input  logic             wrEn,
    input  logic [3:0]       wrAddr,
    input  logic [WIDTH-1:0] wrData
);

    logic [WIDTH-1:0] regs [NUM_REGS];
    logic             wrLive;

    assign wrLive = wrEn && (wrAddr != REG_PC);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= WIDTH'(i);
        end else if (wrLive) begin
            regs[wrAddr] <= wrData;
        end
    end

    // Pc selection comes first so a (discarded) write to R15 never forwards.
    always_comb begin
        if (rdAddr1 == REG_PC)                     rdData1 = pcVal;
        else if (wrLive && (rdAddr1 == wrAddr))    rdData1 = wrData;
        else                                       rdData1 = regs[rdAddr1];

        if (rdAddr2 == REG_PC)                     rdData2 = pcVal;
        else if (wrLive && (rdAddr2 == wrAddr))    rdData2 = wrData;
        else                                       rdData2 = regs[rdAddr2];
    end

endmodule

// File: rtl/stage_id.sv
// Decode stage: decode, regfile read, condition check and RAW hazard detect into an ID/EXE register.
// Latency 1 cycle; hazard (combinational) stalls IF; freeze holds, flush/hazard insert a bubble.
module stage_id
    import arm_defs_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int NUM_REGS = 15
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] pc_in,
    input  logic [31:0]      instruction,
    input  logic             flush,
    input  logic             freeze,
    input  logic [3:0]       status,
    input  logic             wb_en,
    input  logic [3:0]       wb_dest,
    input  logic [WIDTH-1:0] wb_value,
    input  logic             exe_wb_en,
    input  logic [3:0]       exe_dest,
    input  logic             mem_wb_en,
    input  logic [3:0]       mem_dest,
    output logic             hazard,
    output logic [WIDTH-1:0] pc_out,
    output logic [WIDTH-1:0] val_rn,
    output logic [WIDTH-1:0] val_rm,
    output logic [3:0]       exe_cmd,
    output logic             wb_en_out,
    output logic             mem_r_en,
    output logic             mem_w_en,
    output logic             b,
    output logic             s,
    output logic             imm,
    output logic [11:0]      shift_operand,
    output logic [23:0]      signed_imm_24,
    output logic [3:0]       dest
);

    typedef struct packed {
        logic [WIDTH-1:0] pc;
        logic [WIDTH-1:0] valRn;
        logic [WIDTH-1:0] valRm;
        logic [3:0]       cmd;
        logic             wbEn;
        logic             memR;
        logic             memW;
        logic             br;
        logic             sFlag;
        logic             immFlag;
        logic [11:0]      shiftOp;
        logic [23:0]      simm;
        logic [3:0]       dest;
    } idExeT;

    logic [3:0] cond, opcode, rn, rd, rm, src2Addr, cmd;
    logic [1:0] mode;
    logic       iBit, sBit, condOk, dpValid;
    logic       wbEn, memR, memW, isBranch, sFlag, immFlag, useSrc1, useSrc2, isStr;
    logic       src1Hit, src2Hit;
    logic [WIDTH-1:0] rnVal, rmVal;
    idExeT      idExeD, idExeQ;

    assign cond   = instruction[31:28];
    assign mode   = instruction[27:26];
    assign iBit   = instruction[25];
    assign opcode = instruction[24:21];
    assign sBit   = instruction[20];
    assign rn     = instruction[19:16];
    assign rd     = instruction[15:12];
    assign rm     = instruction[3:0];

    always_comb begin
        cmd      = CMD_NONE;
        wbEn     = 1'b0;
        memR     = 1'b0;
        memW     = 1'b0;
        isBranch = 1'b0;
        sFlag    = 1'b0;
        immFlag  = 1'b0;
        useSrc1  = 1'b0;
        useSrc2  = 1'b0;
        isStr    = 1'b0;
        dpValid  = 1'b1;
        case (mode)
            MODE_DP: begin
                useSrc1 = 1'b1;
                useSrc2 = ~iBit;
                case (opcode)
                    OP_MOV: begin cmd = CMD_MOV; wbEn = 1'b1; useSrc1 = 1'b0; end
                    OP_MVN: begin cmd = CMD_MVN; wbEn = 1'b1; useSrc1 = 1'b0; end
                    OP_ADD: begin cmd = CMD_ADD; wbEn = 1'b1; end
                    OP_ADC: begin cmd = CMD_ADC; wbEn = 1'b1; end
                    OP_SUB: begin cmd = CMD_SUB; wbEn = 1'b1; end
                    OP_SBC: begin cmd = CMD_SBC; wbEn = 1'b1; end
                    OP_AND: begin cmd = CMD_AND; wbEn = 1'b1; end
                    OP_ORR: begin cmd = CMD_ORR; wbEn = 1'b1; end
                    OP_EOR: begin cmd = CMD_EOR; wbEn = 1'b1; end
                    OP_CMP: cmd = CMD_SUB;
                    OP_TST: cmd = CMD_AND;
                    default: dpValid = 1'b0;
                endcase
                sFlag   = dpValid & sBit;
                immFlag = dpValid & iBit;
            end
            MODE_MEM: begin
                // Operand usage follows the L bit alone so stores are interlocked
                // even when the opcode field is not the one that enables the access.
                useSrc1 = 1'b1;
                useSrc2 = ~sBit;
                isStr   = ~sBit;
                if (opcode == OP_LDST) begin
                    cmd     = CMD_ADD;
                    immFlag = iBit;
                    memR    = sBit;
                    wbEn    = sBit;
                    memW    = ~sBit;
                end
            end
            MODE_BR: isBranch = 1'b1;
            default: ;
        endcase
    end

    assign src2Addr = isStr ? rd : rm;

    register_file #(.WIDTH(WIDTH), .NUM_REGS(NUM_REGS)) u_regfile (
        .clk     (clk),
        .rst     (rst),
        .pcVal   (pc_in),
        .rdAddr1 (rn),
        .rdAddr2 (src2Addr),
        .rdData1 (rnVal),
        .rdData2 (rmVal),
        .wrEn    (wb_en),
        .wrAddr  (wb_dest),
        .wrData  (wb_value)
    );

    assign condOk  = condPass(cond, status);
    assign src1Hit = useSrc1 && ((exe_wb_en && (rn == exe_dest)) || (mem_wb_en && (rn == mem_dest)));
    assign src2Hit = useSrc2 && ((exe_wb_en && (src2Addr == exe_dest)) ||
                                 (mem_wb_en && (src2Addr == mem_dest)));
    assign hazard  = src1Hit | src2Hit;

    always_comb begin
        idExeD         = '0;
        idExeD.pc      = pc_in;
        idExeD.valRn   = rnVal;
        idExeD.valRm   = rmVal;
        idExeD.cmd     = cmd;
        idExeD.wbEn    = wbEn & condOk;
        idExeD.memR    = memR & condOk;
        idExeD.memW    = memW & condOk;
        idExeD.br      = isBranch & condOk;
        idExeD.sFlag   = sFlag & condOk;
        idExeD.immFlag = immFlag;
        idExeD.shiftOp = instruction[11:0];
        idExeD.simm    = instruction[23:0];
        idExeD.dest    = rd;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)         idExeQ <= '0;
        else if (flush)  idExeQ <= '0;
        else if (freeze) idExeQ <= idExeQ;
        else if (hazard) idExeQ <= '0;
        else             idExeQ <= idExeD;
    end

    assign pc_out        = idExeQ.pc;
    assign val_rn        = idExeQ.valRn;
    assign val_rm        = idExeQ.valRm;
    assign exe_cmd       = idExeQ.cmd;
    assign wb_en_out     = idExeQ.wbEn;
    assign mem_r_en      = idExeQ.memR;
    assign mem_w_en      = idExeQ.memW;
    assign b             = idExeQ.br;
    assign s             = idExeQ.sFlag;
    assign imm           = idExeQ.immFlag;
    assign shift_operand = idExeQ.shiftOp;
    assign signed_imm_24 = idExeQ.simm;
    assign dest          = idExeQ.dest;

endmodule

// File: tb/tb_stage_id.sv
// Directed vector table for the decode stage plus hand sequences for write-through, freeze/flush
// priority and asynchronous reset.
module tb_stage_id;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc_in, instruction, wb_value;
    logic        flush, freeze, wb_en, exe_wb_en, mem_wb_en;
    logic [3:0]  status, wb_dest, exe_dest, mem_dest;
    logic        hazard, wb_en_out, mem_r_en, mem_w_en, b, s, imm;
    logic [31:0] pc_out, val_rn, val_rm;
    logic [3:0]  exe_cmd, dest;
    logic [11:0] shift_operand;
    logic [23:0] signed_imm_24;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    stage_id dut (
        .clk(clk), .rst(rst), .pc_in(pc_in), .instruction(instruction), .flush(flush),
        .freeze(freeze), .status(status), .wb_en(wb_en), .wb_dest(wb_dest), .wb_value(wb_value),
        .exe_wb_en(exe_wb_en), .exe_dest(exe_dest), .mem_wb_en(mem_wb_en), .mem_dest(mem_dest),
        .hazard(hazard), .pc_out(pc_out), .val_rn(val_rn), .val_rm(val_rm), .exe_cmd(exe_cmd),
        .wb_en_out(wb_en_out), .mem_r_en(mem_r_en), .mem_w_en(mem_w_en), .b(b), .s(s), .imm(imm),
        .shift_operand(shift_operand), .signed_imm_24(signed_imm_24), .dest(dest)
    );

    typedef struct {
        string       name;
        logic [31:0] instr;
        logic [3:0]  st;
        logic        eW;
        logic [3:0]  eD;
        logic        mW;
        logic [3:0]  mD;
        logic        hz;
        logic [3:0]  cmd;
        logic        chkCmd;
        logic [5:0]  ctl;      // {wb_en_out, mem_r_en, mem_w_en, b, s, imm}
        logic        chkData;
        logic [31:0] rn;
        logic [31:0] rm;
        logic        chkRm;
        logic [3:0]  dst;
    } vecT;

    function automatic vecT mkVec(input string name, input logic [31:0] instr, input logic [3:0] st,
                                  input logic eW, input logic [3:0] eD, input logic mW,
                                  input logic [3:0] mD, input logic hz, input logic [3:0] cmd,
                                  input logic chkCmd, input logic [5:0] ctl, input logic chkData,
                                  input logic [31:0] rn, input logic [31:0] rm, input logic chkRm,
                                  input logic [3:0] dst);
        vecT v;
        v.name = name; v.instr = instr; v.st = st; v.eW = eW; v.eD = eD; v.mW = mW; v.mD = mD;
        v.hz = hz; v.cmd = cmd; v.chkCmd = chkCmd; v.ctl = ctl; v.chkData = chkData;
        v.rn = rn; v.rm = rm; v.chkRm = chkRm; v.dst = dst;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idleInputs();
        flush = 1'b0; freeze = 1'b0; wb_en = 1'b0; wb_dest = 4'd0; wb_value = 32'd0;
        exe_wb_en = 1'b0; exe_dest = 4'd0; mem_wb_en = 1'b0; mem_dest = 4'd0; status = 4'd0;
    endtask

    vecT vecs[$];
    logic [5:0]  ctlNow;
    logic [31:0] pcNow;

    initial begin
        rst = 1'b1;
        pc_in = 32'd0;
        instruction = 32'd0;
        idleInputs();
        tick();
        tick();
        chk("rst_pc_out", pc_out, 32'd0);
        chk("rst_val_rn", val_rn, 32'd0);
        chk("rst_ctl", 32'({wb_en_out, mem_r_en, mem_w_en, b, s, imm}), 32'd0);
        chk("rst_exe_cmd", 32'(exe_cmd), 32'd0);
        chk("rst_dest", 32'(dest), 32'd0);
        rst = 1'b0;

        //                name           instr         st     eW eD    mW mD    hz cmd   cc ctl        cd rn        rm     cr dst
        vecs.push_back(mkVec("add",        32'hE0821003, 4'h0, 0, 4'd0, 0, 4'd0, 0, 4'h2, 1, 6'b100000, 1, 32'd2,    32'd3, 1, 4'd1));
        vecs.push_back(mkVec("adds",       32'hE0921003, 4'h0, 0, 4'd0, 0, 4'd0, 0, 4'h2, 1, 6'b100010, 1, 32'd2,    32'd3, 1, 4'd1));
        vecs.push_back(mkVec("moveq_z0",   32'h03A00005, 4'h0, 0, 4'd0, 0, 4'd0, 0, 4'h0, 0, 6'b000001, 1, 32'd0,    32'd0, 0, 4'd0));
        vecs.push_back(mkVec("moveq_z1",   32'h03A00005, 4'h4, 0, 4'd0, 0, 4'd0, 0, 4'h1, 1, 6'b100001, 1, 32'd0,    32'd0, 0, 4'd0));
        vecs.push_back(mkVec("add_haz_ex", 32'hE0821003, 4'h0, 1, 4'd2, 0, 4'd0, 1, 4'h0, 1, 6'b000000, 0, 32'd0,    32'd0, 0, 4'd0));
        vecs.push_back(mkVec("add_ex_off", 32'hE0821003, 4'h0, 0, 4'd2, 0, 4'd0, 0, 4'h2, 1, 6'b100000, 1, 32'd2,    32'd3, 1, 4'd1));
        vecs.push_back(mkVec("mov_no_rn",  32'hE1A01002, 4'h0, 1, 4'd0, 0, 4'd0, 0, 4'h1, 1, 6'b100000, 1, 32'd0,    32'd2, 1, 4'd1));
        vecs.push_back(mkVec("mov_rm_haz", 32'hE1A01002, 4'h0, 1, 4'd2, 0, 4'd0, 1, 4'h0, 1, 6'b000000, 0, 32'd0,    32'd0, 0, 4'd0));
        vecs.push_back(mkVec("str_haz_mem",32'hE5854000, 4'h0, 0, 4'd0, 1, 4'd4, 1, 4'h0, 1, 6'b000000, 0, 32'd0,    32'd0, 0, 4'd0));
        vecs.push_back(mkVec("str",        32'hE4854000, 4'h0, 0, 4'd0, 0, 4'd4, 0, 4'h2, 1, 6'b001000, 1, 32'd5,    32'd4, 1, 4'd4));
        vecs.push_back(mkVec("ldr_haz_mem",32'hE4926000, 4'h0, 0, 4'd0, 1, 4'd2, 1, 4'h0, 1, 6'b000000, 0, 32'd0,    32'd0, 0, 4'd0));
        vecs.push_back(mkVec("ldr_rd_free",32'hE4926000, 4'h0, 0, 4'd0, 1, 4'd6, 0, 4'h2, 1, 6'b110000, 1, 32'd2,    32'd0, 0, 4'd6));
        vecs.push_back(mkVec("cmp",        32'hE1520003, 4'h0, 0, 4'd0, 0, 4'd0, 0, 4'h4, 1, 6'b000010, 1, 32'd2,    32'd3, 1, 4'd0));
        vecs.push_back(mkVec("addge_pass", 32'hA0821003, 4'h9, 0, 4'd0, 0, 4'd0, 0, 4'h2, 1, 6'b100000, 1, 32'd2,    32'd3, 1, 4'd1));
        vecs.push_back(mkVec("addge_fail", 32'hA0821003, 4'h8, 0, 4'd0, 0, 4'd0, 0, 4'h0, 0, 6'b000000, 1, 32'd2,    32'd3, 1, 4'd1));
        vecs.push_back(mkVec("nv_adds",    32'hF0921003, 4'hF, 0, 4'd0, 0, 4'd0, 0, 4'h0, 0, 6'b000000, 1, 32'd2,    32'd3, 1, 4'd1));
        vecs.push_back(mkVec("b_rn15",     32'hEAFFFFFF, 4'h0, 1, 4'd15,0, 4'd0, 0, 4'h0, 1, 6'b000100, 0, 32'd0,    32'd0, 0, 4'd0));
        vecs.push_back(mkVec("noop",       32'hEC000000, 4'h0, 1, 4'd0, 1, 4'd0, 0, 4'h0, 1, 6'b000000, 1, 32'd0,    32'd0, 1, 4'd0));
        vecs.push_back(mkVec("hi_pass",    32'h80821003, 4'h2, 0, 4'd0, 0, 4'd0, 0, 4'h2, 1, 6'b100000, 1, 32'd2,    32'd3, 1, 4'd1));
        vecs.push_back(mkVec("ls_fail",    32'h90821003, 4'h2, 0, 4'd0, 0, 4'd0, 0, 4'h0, 0, 6'b000000, 1, 32'd2,    32'd3, 1, 4'd1));
        vecs.push_back(mkVec("mvn",        32'hE1E01002, 4'h0, 0, 4'd0, 0, 4'd0, 0, 4'h9, 1, 6'b100000, 1, 32'd0,    32'd2, 1, 4'd1));

        foreach (vecs[i]) begin
            idleInputs();
            pcNow       = 32'h1000 + 32'(i) * 4;
            pc_in       = pcNow;
            instruction = vecs[i].instr;
            status      = vecs[i].st;
            exe_wb_en   = vecs[i].eW;
            exe_dest    = vecs[i].eD;
            mem_wb_en   = vecs[i].mW;
            mem_dest    = vecs[i].mD;
            #1;
            chk({vecs[i].name, "_hazard"}, 32'(hazard), 32'(vecs[i].hz));
            tick();
            ctlNow = {wb_en_out, mem_r_en, mem_w_en, b, s, imm};
            chk({vecs[i].name, "_ctl"}, 32'(ctlNow), 32'(vecs[i].ctl));
            if (vecs[i].chkCmd) chk({vecs[i].name, "_cmd"}, 32'(exe_cmd), 32'(vecs[i].cmd));
            if (vecs[i].chkData) begin
                chk({vecs[i].name, "_pc"}, pc_out, pcNow);
                chk({vecs[i].name, "_val_rn"}, val_rn, vecs[i].rn);
                chk({vecs[i].name, "_dest"}, 32'(dest), 32'(vecs[i].dst));
                chk({vecs[i].name, "_shift"}, 32'(shift_operand), 32'(vecs[i].instr[11:0]));
            end
            if (vecs[i].chkRm) chk({vecs[i].name, "_val_rm"}, val_rm, vecs[i].rm);
        end

        // Write-through, persistence and the R15 write being discarded.
        idleInputs();
        instruction = 32'hE0821003;
        wb_en = 1'b1; wb_dest = 4'd2; wb_value = 32'h0000DEAD;
        tick();
        chk("wt_val_rn", val_rn, 32'h0000DEAD);
        wb_en = 1'b0;
        tick();
        chk("r2_kept", val_rn, 32'h0000DEAD);
        instruction = 32'hE08F1003;
        pc_in = 32'h2000;
        wb_en = 1'b1; wb_dest = 4'd15; wb_value = 32'h1234;
        tick();
        chk("r15_is_pc", val_rn, 32'h2000);

        // Freeze holds outputs while the regfile still takes a write.
        idleInputs();
        pc_in = 32'h2100;
        instruction = 32'hE0821003;
        tick();
        instruction = 32'hE1520003;
        freeze = 1'b1;
        wb_en = 1'b1; wb_dest = 4'd7; wb_value = 32'h77;
        tick();
        chk("frz_cmd", 32'(exe_cmd), 32'h2);
        chk("frz_wb", 32'(wb_en_out), 32'd1);
        chk("frz_val_rn", val_rn, 32'h0000DEAD);
        chk("frz_pc", pc_out, 32'h2100);
        freeze = 1'b0; wb_en = 1'b0;
        instruction = 32'hE0871003;
        tick();
        chk("r7_write_in_freeze", val_rn, 32'h77);

        // Flush beats freeze; flush alone also bubbles.
        freeze = 1'b1; flush = 1'b1;
        tick();
        chk("frzflush_ctl", 32'({wb_en_out, mem_r_en, mem_w_en, b, s, imm}), 32'd0);
        chk("frzflush_cmd", 32'(exe_cmd), 32'd0);
        chk("frzflush_val_rn", val_rn, 32'd0);
        freeze = 1'b0; flush = 1'b0;
        instruction = 32'hE0821003;
        tick();
        chk("reload_wb", 32'(wb_en_out), 32'd1);
        flush = 1'b1;
        tick();
        chk("flush_wb", 32'(wb_en_out), 32'd0);
        chk("flush_cmd", 32'(exe_cmd), 32'd0);
        flush = 1'b0;

        // Branch, then asynchronous reset in the middle of a cycle.
        pc_in = 32'h3000;
        instruction = 32'hEAFFFFFF;
        tick();
        chk("b_flag", 32'(b), 32'd1);
        chk("b_simm", 32'(signed_imm_24), 32'h00FFFFFF);
        chk("b_wb", 32'(wb_en_out), 32'd0);
        chk("b_pc", pc_out, 32'h3000);
        #2 rst = 1'b1;
        #1;
        chk("arst_b", 32'(b), 32'd0);
        chk("arst_simm", 32'(signed_imm_24), 32'd0);
        chk("arst_pc", pc_out, 32'd0);
        tick();
        rst = 1'b0;
        instruction = 32'hE0821003;
        tick();
        chk("arst_r2_restored", val_rn, 32'd2);
        chk("arst_r3_restored", val_rm, 32'd3);
        instruction = 32'hE0871003;
        tick();
        chk("arst_r7_restored", val_rn, 32'd7);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
